aes_shift_rows_pipe: RTL and testbench

//  Pipelined, bidirectional AES ShiftRows/InvShiftRows engine with valid/ready flow control.

---
 rtl/aes_shift_rows_pipe.sv | 105 ++++++++++
 tb/tb_aes_shift_rows_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_shift_rows_pipe.sv
// Elastic STAGES-deep pipeline applying AES ShiftRows or InvShiftRows (chosen per beat)
// to a 128-bit state, carrying a side-band tag; valid/ready on both sides, synchronous flush.
module aes_shift_rows_pipe #(
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_inv,
  output logic [TAG_W-1:0] out_tag,
  output logic [127:0]     out_data,
  output logic [3:0]       occupancy
);

  // Handshake: a beat moves across a boundary on a rising edge iff valid && ready
  // are both high there; in_ready depends combinationally on out_ready and flush.

  logic [127:0]     w_fwd;
  logic [127:0]     w_inv;
  logic [127:0]     w_perm;
  logic             w_accept;
  logic [STAGES-1:0] w_adv;
  logic [3:0]       w_occ;

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_inv;
  logic [TAG_W-1:0]  r_tag  [STAGES];
  logic [127:0]      r_data [STAGES];

  // Byte (row r, col c) lives at index 4c+r, MSB first.
  for (genvar gr = 0; gr < 4; gr++) begin : g_row
    for (genvar gc = 0; gc < 4; gc++) begin : g_col
      localparam int DST  = 127 - 8 * (4 * gc + gr);
      localparam int FSRC = 127 - 8 * (4 * ((gc + gr) % 4) + gr);
      localparam int ISRC = 127 - 8 * (4 * ((gc - gr + 4) % 4) + gr);
      assign w_fwd[DST -: 8] = in_data[FSRC -: 8];
      assign w_inv[DST -: 8] = in_data[ISRC -: 8];
    end
  end

  assign w_perm = in_inv ? w_inv : w_fwd;

  // Stage g may load iff some stage at or after g is empty, or the sink takes a beat.
  for (genvar g = 0; g < STAGES; g++) begin : g_adv
    assign w_adv[g] = out_ready | ~(&r_valid[STAGES-1:g]);
  end

  assign in_ready = w_adv[0] & ~flush;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_inv   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (flush) begin
        r_valid <= '0;
      end else begin
        if (w_adv[0]) r_valid[0] <= w_accept;
        for (int i = 1; i < STAGES; i++) begin
          if (w_adv[i]) r_valid[i] <= r_valid[i-1];
        end
      end
      if (w_accept) begin
        r_inv[0]  <= in_inv;
        r_tag[0]  <= in_tag;
        r_data[0] <= w_perm;
      end
      // Payload moves only with a valid beat so empty stages keep stable old data.
      for (int i = 1; i < STAGES; i++) begin
        if (!flush && w_adv[i] && r_valid[i-1]) begin
          r_inv[i]  <= r_inv[i-1];
          r_tag[i]  <= r_tag[i-1];
          r_data[i] <= r_data[i-1];
        end
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_occ = w_occ + 4'(r_valid[i]);
    end
  end

  assign occupancy = w_occ;
  assign out_valid = r_valid[STAGES-1];
  assign out_inv   = r_inv[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];
  assign out_data  = r_data[STAGES-1];

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Scoreboard bench for aes_shift_rows_pipe: driver pushes expected {inv,tag,data} beats,
// an independent negedge monitor pops and compares every output handshake.
module tb_aes_shift_rows_pipe;

  localparam int STAGES = 2;
  localparam int TAG_W  = 4;
  localparam int W      = 1 + TAG_W + 128;

  localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] SEQ_IN   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_FWD  = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] SEQ_INV  = 128'h000d0a0704010e0b0805020f0c090603;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             in_inv;
  logic [TAG_W-1:0] in_tag;
  logic [127:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_inv;
  logic [TAG_W-1:0] out_tag;
  logic [127:0]     out_data;
  logic [3:0]       occupancy;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int last_out_cyc = 0;
  logic [W-1:0] exp_q[$];

  aes_shift_rows_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv), .in_tag(in_tag), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv), .out_tag(out_tag),
    .out_data(out_data), .occupancy(occupancy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] sr_model(input logic inv, input logic [127:0] d);
    logic [127:0] o;
    int s;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127 - 8 * (4 * c + r) -: 8] = d[127 - 8 * (4 * s + r) -: 8];
      end
    end
    return o;
  endfunction

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send(input logic inv, input logic [TAG_W-1:0] tag,
                      input logic [127:0] data, input logic [127:0] exp_data);
    int  n;
    bit  ok;
    in_valid = 1'b1;
    in_inv   = inv;
    in_tag   = tag;
    in_data  = data;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: tag %0d not accepted in 200 cycles", tag);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back({inv, tag, exp_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check(name, W'(exp_q.size()), W'(0));
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic         prev_stall = 1'b0;
  logic         prev_flush = 1'b0;
  logic [W-1:0] prev_out   = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !prev_flush) begin
        check("hold_valid", W'(out_valid), W'(1));
        check("hold_beat", {out_inv, out_tag, out_data}, prev_out);
      end
      check("occ_bound", W'(occupancy <= 4'(STAGES)), W'(1));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL out_unexpected: got %h expected no beat", {out_inv, out_tag, out_data});
        end else begin
          check("out_beat", {out_inv, out_tag, out_data}, exp_q.pop_front());
        end
        last_out_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_inv, out_tag, out_data};
      prev_flush = flush;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [127:0] d;
  int           c0;
  int           accepted;
  bit           rand_on;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inv = 1'b0;
    in_tag = '0; in_data = '0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_beat", {out_inv, out_tag, out_data}, W'(0));
    check("rst_occupancy", W'(occupancy), W'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Forward FIPS-197 vector with exact latency.
    send(1'b0, 4'h1, FIPS_IN, FIPS_OUT);
    idle();
    for (int k = 1; k <= STAGES; k++) begin
      @(negedge clk);
      check("latency_valid", W'(out_valid), W'(k == STAGES));
    end
    @(posedge clk);
    #1;

    // Inverse and index-pattern vectors.
    send(1'b1, 4'h2, FIPS_OUT, FIPS_IN);
    send(1'b0, 4'h3, SEQ_IN, SEQ_FWD);
    send(1'b1, 4'h4, SEQ_IN, SEQ_INV);
    idle();
    drain("drain_directed");

    // Streaming: 20 back-to-back beats, alternating direction.
    c0 = cyc;
    for (int i = 0; i < 20; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(1'(i), TAG_W'(i), d, sr_model(1'(i), d));
    end
    idle();
    check("stream_in_rate", W'(cyc - c0), W'(20));
    drain("drain_stream");
    check("stream_out_rate", W'(last_out_cyc - c0), W'(19 + STAGES));

    // Backpressure: hold out_ready low while the source keeps offering beats.
    out_ready = 1'b0;
    accepted  = 0;
    d = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_inv = 1'(accepted); in_tag = TAG_W'(accepted + 5); in_data = d;
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({in_inv, in_tag, sr_model(in_inv, d)});
        accepted++;
        d = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk);
      #1;
    end
    in_inv = 1'(accepted); in_tag = TAG_W'(accepted + 5); in_data = d;
    check("bp_accepted", W'(accepted), W'(STAGES));
    check("bp_occupancy", W'(occupancy), W'(STAGES));
    check("bp_in_ready", W'(in_ready), W'(0));
    out_ready = 1'b1;
    @(negedge clk);
    check("full_ready_accept", W'(in_ready), W'(1));
    exp_q.push_back({in_inv, in_tag, sr_model(in_inv, d)});
    @(posedge clk);
    #1;
    idle();
    check("full_accept_emit_occ", W'(occupancy), W'(STAGES));
    drain("drain_bp");

    // Flush with a partly filled pipe: in_ready must drop during the flush cycle.
    out_ready = 1'b0;
    send(1'b0, 4'h9, SEQ_IN, SEQ_FWD);
    idle();
    repeat (STAGES) @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = FIPS_IN; in_tag = 4'hA; in_inv = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", W'(in_ready), W'(0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    idle();
    exp_q.delete();
    check("flush1_occ", W'(occupancy), W'(0));

    // Flush with a full pipe.
    for (int i = 0; i < STAGES; i++) send(1'b1, TAG_W'(i), FIPS_OUT, FIPS_IN);
    idle();
    check("fill_occ", W'(occupancy), W'(STAGES));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    check("flush2_occ", W'(occupancy), W'(0));
    check("flush2_valid", W'(out_valid), W'(0));
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) send(1'b0, TAG_W'(i + 3), SEQ_IN, SEQ_FWD);
    idle();
    @(posedge clk);
    #3 rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_out_valid", W'(out_valid), W'(0));
    check("arst_out_beat", {out_inv, out_tag, out_data}, W'(0));
    check("arst_occupancy", W'(occupancy), W'(0));
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("arst_in_ready", W'(in_ready), W'(1));

    // Random valid/ready traffic.
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          idle();
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          d = {$urandom, $urandom, $urandom, $urandom};
          in_inv = 1'($urandom_range(0, 1));
          send(in_inv, TAG_W'(i), d, sr_model(in_inv, d));
        end
        idle();
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain("drain_random");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
